apb_slave_regfile: RTL

//  APB slave register file: the completer on the bus driven by the team's APB master.

---
 rtl/apb_slave_regfile.sv | 132 +++++++++++++
 1 files changed

// File: rtl/apb_slave_regfile.sv
// APB completer holding four read-only ID words and NUM_REGS-4 read/write words,
// with a fixed number of wait states per access and a completed-transfer counter.
module apb_slave_regfile #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID0         = 32'h00000309,
  parameter logic [31:0] ID1         = 32'h07122023,
  parameter logic [31:0] ID2         = 32'h444F4C5A,
  parameter logic [31:0] ID3         = 32'h44454E49
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [15:0] xfer_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int         NUM_RW     = NUM_REGS - 4;
  localparam int         IW         = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
  localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
  localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          write_q;
  logic [31:0]   rw_q [NUM_RW];

  logic [31:0]   sel_addr;
  logic          sel_write;
  logic [5:0]    sel_idx;
  logic [IW-1:0] rw_idx;
  logic          sel_err;
  logic [31:0]   sel_rdata;

  // In IDLE the live bus is decoded (zero-wait response); afterwards only the latched copy.
  always_comb begin
    sel_addr  = (state == S_IDLE) ? PADDR  : addr_q;
    sel_write = (state == S_IDLE) ? PWRITE : write_q;
    sel_idx   = sel_addr[7:2];
    rw_idx    = IW'(sel_idx - 6'd4);
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:8] != 24'd0) ||
                ({1'b0, sel_idx} >= NUM_REGS_W) || (sel_write && (sel_idx < 6'd4));
    sel_rdata = '0;
    if (!sel_err && !sel_write) begin
      if (sel_idx < 6'd4) begin
        case (sel_idx[1:0])
          2'd0:    sel_rdata = ID0;
          2'd1:    sel_rdata = ID1;
          2'd2:    sel_rdata = ID2;
          default: sel_rdata = ID3;
        endcase
      end else begin
        sel_rdata = rw_q[rw_idx];
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      PRDATA   <= '0;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
      xfer_cnt <= '0;
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (PSEL && !PENABLE) begin
            addr_q   <= PADDR;
            write_q  <= PWRITE;
            wdata_q  <= PWDATA;
            wait_cnt <= WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
              PREADY  <= 1'b1;
              PSLVERR <= sel_err;
              PRDATA  <= sel_rdata;
              state   <= S_DONE;
            end else begin
              state   <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!PSEL) begin
            state   <= S_IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) begin
              PREADY  <= 1'b1;
              PSLVERR <= sel_err;
              PRDATA  <= sel_rdata;
              state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Commit only if the master is still in its access phase; otherwise it is an abort.
          if (PSEL && PENABLE && PREADY) begin
            if (write_q && !PSLVERR) rw_q[rw_idx] <= wdata_q;
            xfer_cnt <= xfer_cnt + 16'd1;
          end
          state   <= S_IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
